// File: rtl/sipo_pkg.sv
// sipo_pkg: shared FSM state encoding and frame bit constants for the SIPO frame loader.
package sipo_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, HOLD} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/sipo_frame_loader_if.sv
// sipo_frame_loader_if: serial input strobe plus parallel valid/ready word and status pulses.
interface sipo_frame_loader_if #(parameter int WIDTH = 4);
  logic sin, sin_valid, pready, pvalid, perr, ovr, busy;
  logic [WIDTH-1:0] pdata;
  modport master (output sin, sin_valid, pready, input pdata, pvalid, perr, ovr, busy);
  modport slave (input sin, sin_valid, pready, output pdata, pvalid, perr, ovr, busy);
endinterface

// File: rtl/sipo_shreg.sv
// sipo_shreg: right-shift register, serial input enters at the MSB so the first bit lands in bit 0.
module sipo_shreg #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (en) q <= {din, q[WIDTH-1:1]};
endmodule

// File: rtl/sipo_frame_loader.sv
// sipo_frame_loader: frames a serial bit stream, checks parity/stop, and hands the word off via valid/ready.
module sipo_frame_loader
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  sipo_frame_loader_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic par, good, start, shift;
  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (.clk(clk), .rst(rst), .en(shift), .din(bus.sin), .q(sr));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = DATA;
      DATA: if (bus.sin_valid && cnt == LAST) nxt = PARITY_EN ? PAR : STOP;
      PAR:  if (bus.sin_valid) nxt = STOP;
      STOP: if (bus.sin_valid) nxt = good ? HOLD : IDLE;
      HOLD: if (bus.pready) nxt = start ? DATA : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // A completed handshake frees HOLD to take a start bit in the same cycle.
  assign start = bus.sin_valid && bus.sin == START_BIT && (state == IDLE || (state == HOLD && bus.pready));
  assign shift = state == DATA && bus.sin_valid;
  assign good = bus.sin == STOP_BIT && (!PARITY_EN || !(^sr ^ par));
  assign bus.pvalid = state == HOLD;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      par <= 1'b0;
      bus.pdata <= '0;
      bus.perr <= 1'b0;
      bus.ovr <= 1'b0;
    end else begin
      cnt <= start ? '0 : shift ? cnt + 1'b1 : cnt;
      if (state == PAR && bus.sin_valid) par <= bus.sin;
      if (state == STOP && bus.sin_valid && good) bus.pdata <= sr;
      bus.perr <= state == STOP && bus.sin_valid && !good;
      bus.ovr <= state == HOLD && bus.sin_valid && !bus.pready;
    end
endmodule

// File: tb/tb_sipo_frame_loader.sv
// tb_sipo_frame_loader: directed frames with hand-computed expectations for the SIPO frame loader.
module tb_sipo_frame_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int npass = 0;
  int ntot = 0;
  sipo_frame_loader_if #(.WIDTH(4)) bus ();
  sipo_frame_loader #(.WIDTH(4), .PARITY_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    bus.sin_valid = v;
    bus.sin = b;
  endtask
  // start, 4 data bits LSB-first, parity, stop; pready applied with the start bit
  task automatic frame(input logic [3:0] d, input logic p, input logic s, input logic rdy);
    drive(1'b1, 1'b0);
    bus.pready = rdy;
    for (int i = 0; i < 4; i++) drive(1'b1, d[i]);
    drive(1'b1, p);
    drive(1'b1, s);
    drive(1'b0, 1'b0);
  endtask
  initial begin
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    bus.pready = 1'b0;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pvalid", 32'(bus.pvalid), 0);
    chk("rst_pdata", 32'(bus.pdata), 0);
    chk("rst_perr", 32'(bus.perr), 0);
    chk("rst_ovr", 32'(bus.ovr), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b1;
    repeat (3) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk("idle_line_busy", 32'(bus.busy), 0);
    frame(4'hA, 1'b0, 1'b1, 1'b1);
    chk("good_pvalid", 32'(bus.pvalid), 1);
    chk("good_pdata", 32'(bus.pdata), 32'hA);
    chk("good_perr", 32'(bus.perr), 0);
    drive(1'b0, 1'b0);
    chk("good_pvalid_1cyc", 32'(bus.pvalid), 0);
    frame(4'hA, 1'b1, 1'b1, 1'b1);
    chk("par_perr", 32'(bus.perr), 1);
    chk("par_pvalid", 32'(bus.pvalid), 0);
    chk("par_pdata", 32'(bus.pdata), 32'hA);
    drive(1'b0, 1'b0);
    chk("par_perr_1cyc", 32'(bus.perr), 0);
    frame(4'h3, 1'b0, 1'b0, 1'b1);
    chk("stop_perr", 32'(bus.perr), 1);
    chk("stop_pvalid", 32'(bus.pvalid), 0);
    frame(4'h5, 1'b0, 1'b1, 1'b0);
    chk("bp_pvalid", 32'(bus.pvalid), 1);
    chk("bp_pdata", 32'(bus.pdata), 32'h5);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    chk("bp_ovr1", 32'(bus.ovr), 1);
    drive(1'b0, 1'b0);
    chk("bp_ovr2", 32'(bus.ovr), 1);
    drive(1'b0, 1'b0);
    chk("bp_ovr_end", 32'(bus.ovr), 0);
    chk("bp_pdata_kept", 32'(bus.pdata), 32'h5);
    chk("bp_pvalid_kept", 32'(bus.pvalid), 1);
    bus.pready = 1'b1;
    drive(1'b0, 1'b0);
    chk("bp_release", 32'(bus.pvalid), 0);
    frame(4'h5, 1'b0, 1'b1, 1'b0);
    chk("zb_hold", 32'(bus.pvalid), 1);
    drive(1'b1, 1'b0);
    bus.pready = 1'b1;
    drive(1'b1, 1'b1);
    chk("zb_no_ovr", 32'(bus.ovr), 0);
    chk("zb_busy", 32'(bus.busy), 1);
    chk("zb_pvalid_low", 32'(bus.pvalid), 0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk("zb_pvalid", 32'(bus.pvalid), 1);
    chk("zb_pdata", 32'(bus.pdata), 32'h3);
    chk("zb_perr", 32'(bus.perr), 0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("mid_busy", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_pdata", 32'(bus.pdata), 0);
    @(negedge clk);
    rst = 1'b1;
    frame(4'hC, 1'b0, 1'b1, 1'b1);
    chk("after_rst_pvalid", 32'(bus.pvalid), 1);
    chk("after_rst_pdata", 32'(bus.pdata), 32'hC);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
